// File: rtl/conv_enc.sv
// conv_enc: rate-1/2, constraint-length-3 convolutional encoder, generators
// (7,5) octal. Takes one information bit per input handshake and emits one
// 2-bit channel symbol {c1, c0} per bit. After the bit flagged in_last it
// appends TAIL_LEN zero bits, so the decoder trellis always ends in state 00.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_bit / in_last are valid
//   in_ready   encoder accepts a bit this cycle
//   in_bit     information bit u_k
//   in_last    final information bit of the frame
//   out_valid  out_sym / out_last are valid
//   out_ready  downstream takes the symbol this cycle
//   out_sym    encoded symbol {c1, c0}
//   out_last   final tail symbol of the frame
//   busy       frame in progress or a symbol is still held
module conv_enc #(
    parameter int TAIL_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
    output logic       out_last,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_t;

    localparam logic [3:0] TAIL_LAST = 4'(TAIL_LEN - 1);

    state_t     state_q, state_d;
    logic [1:0] sr_q, sr_d;             // {u_{k-1}, u_{k-2}}
    logic [3:0] tail_cnt_q, tail_cnt_d;
    logic       out_valid_q, out_valid_d;
    logic [1:0] out_sym_q, out_sym_d;
    logic       out_last_q, out_last_d;

    logic can_load;
    logic accept;
    logic tail_load;

    // Generator 7 (111) feeds c1, generator 5 (101) feeds c0.
    function automatic logic [1:0] encode(input logic u, input logic [1:0] sr);
        return {u ^ sr[1] ^ sr[0], u ^ sr[0]};
    endfunction

    // The single output register may load when empty or being drained.
    assign can_load  = !out_valid_q || out_ready;
    assign in_ready  = can_load && (state_q != TAIL) && !rst;
    assign accept    = in_valid && in_ready;
    assign tail_load = can_load && (state_q == TAIL);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        tail_cnt_d  = tail_cnt_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_last_d  = out_last_q;

        if (accept) begin
            out_sym_d   = encode(in_bit, sr_q);
            sr_d        = {in_bit, sr_q[1]};
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            if (in_last) begin
                state_d    = TAIL;
                tail_cnt_d = 4'd0;
            end else begin
                state_d = DATA;
            end
        end else if (tail_load) begin
            out_sym_d   = encode(1'b0, sr_q);
            out_valid_d = 1'b1;
            if (tail_cnt_q == TAIL_LAST) begin
                // sr would already be 00 here; forcing it keeps the next
                // frame anchored to the zero state regardless.
                out_last_d = 1'b1;
                state_d    = IDLE;
                sr_d       = 2'b00;
                tail_cnt_d = 4'd0;
            end else begin
                out_last_d = 1'b0;
                sr_d       = {1'b0, sr_q[1]};
                tail_cnt_d = tail_cnt_q + 4'd1;
            end
        end else if (out_ready) begin
            // Symbol taken and nothing new to load: register empties.
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= 2'b00;
            tail_cnt_q  <= 4'd0;
            out_valid_q <= 1'b0;
            out_sym_q   <= 2'b00;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            tail_cnt_q  <= tail_cnt_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE) || out_valid_q;

endmodule

// File: tb/tb_conv_enc.sv
// Testbench for conv_enc: two instances (TAIL_LEN=2 and TAIL_LEN=4) driven
// by directed and random frames, compared every cycle against a behavioural
// model built from the generator polynomials and frame/tail rules.
module tb_conv_enc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid  [2];
    logic       in_bit    [2];
    logic       in_last   [2];
    logic       out_ready [2];
    logic       in_ready  [2];
    logic       out_valid [2];
    logic       out_last  [2];
    logic       busy      [2];
    logic [1:0] out_sym   [2];

    conv_enc #(.TAIL_LEN(2)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_bit(in_bit[0]), .in_last(in_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sym(out_sym[0]),
        .out_last(out_last[0]), .busy(busy[0])
    );

    conv_enc #(.TAIL_LEN(4)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_bit(in_bit[1]), .in_last(in_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sym(out_sym[1]),
        .out_last(out_last[1]), .busy(busy[1])
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state per instance
    logic [2:0] exp_q   [2][$];   // pending {last, c1, c0}
    logic [2:0] log_sym [2][$];   // symbols actually taken from the DUT
    int         log_cyc [2][$];
    bit [31:0]  hist    [2];      // previous information bits of the frame, newest in bit 0
    bit         in_frame[2];
    int         tl      [2];
    int         ready_mode [2];   // 0: always 1, 1: random, 2: 1,0,0 pattern, 3: always 0
    int         pat_cnt [2];

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Symbol from the generator polynomials applied to window {u, u_{k-1}, u_{k-2}}.
    function automatic logic [2:0] model_sym(input bit u, input bit u1, input bit u2, input bit last);
        logic [2:0] w;
        w = {u, u1, u2};
        return {last, ^(w & 3'b111), ^(w & 3'b101)};
    endfunction

    task automatic model_accept(input int i, input bit b, input bit last);
        exp_q[i].push_back(model_sym(b, hist[i][0], hist[i][1], 1'b0));
        hist[i] = {hist[i][30:0], b};
        if (last) begin
            for (int t = 0; t < tl[i]; t++) begin
                exp_q[i].push_back(model_sym(1'b0, hist[i][0], hist[i][1], t == tl[i] - 1));
                hist[i] = {hist[i][30:0], 1'b0};
            end
            hist[i]     = '0;
            in_frame[i] = 1'b0;
        end else begin
            in_frame[i] = 1'b1;
        end
    endtask

    // Compare process: inputs change just after posedge, so values seen at
    // negedge are exactly what the next posedge samples.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int sz;
            sz = exp_q[i].size();
            if (rst) begin
                chk($sformatf("u%0d.in_ready_rst", i), int'(in_ready[i]), 0);
                exp_q[i].delete();
                hist[i]     = '0;
                in_frame[i] = 1'b0;
            end else begin
                chk($sformatf("u%0d.out_valid", i), int'(out_valid[i]), int'(sz != 0));
                chk($sformatf("u%0d.busy", i), int'(busy[i]), int'(in_frame[i] || sz != 0));
                chk($sformatf("u%0d.in_ready", i), int'(in_ready[i]),
                    int'(sz == 0 || (sz == 1 && out_ready[i])));
                if (out_valid[i] && sz != 0) begin
                    chk($sformatf("u%0d.sym", i), int'({out_last[i], out_sym[i]}), int'(exp_q[i][0]));
                    if (out_ready[i]) begin
                        log_sym[i].push_back({out_last[i], out_sym[i]});
                        log_cyc[i].push_back(cyc);
                        void'(exp_q[i].pop_front());
                    end
                end
                if (in_valid[i] && in_ready[i]) model_accept(i, in_bit[i], in_last[i]);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            case (ready_mode[i])
                0: out_ready[i] = 1'b1;
                1: out_ready[i] = ($urandom_range(0, 3) != 0);
                2: out_ready[i] = (pat_cnt[i] % 3 == 0);
                default: out_ready[i] = 1'b0;
            endcase
            pat_cnt[i]++;
        end
    end

    // Driver tasks start and end aligned to a posedge.
    task automatic drive_bit(input int i, input bit b, input bit last);
        int budget;
        budget = 0;
        #2;
        in_valid[i] = 1'b1;
        in_bit[i]   = b;
        in_last[i]  = last;
        forever begin
            @(negedge clk);
            if (in_ready[i]) break;
            budget++;
            if (budget > 300) begin
                chk($sformatf("u%0d.accept_timeout", i), 1, 0);
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int i, input int n);
        #2;
        in_valid[i] = 1'b0;
        in_bit[i]   = 1'($urandom);
        in_last[i]  = 1'($urandom);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input int i, input logic [15:0] bits, input int len, input int maxgap);
        for (int k = 0; k < len; k++) begin
            if (maxgap > 0) idle_cycles(i, int'($urandom_range(0, maxgap)));
            drive_bit(i, bits[k], k == len - 1);
        end
    endtask

    task automatic wait_idle(input int i);
        int budget;
        budget = 0;
        #2;
        in_valid[i] = 1'b0;
        while (exp_q[i].size() != 0 || in_frame[i]) begin
            @(posedge clk);
            budget++;
            if (budget > 500) begin
                chk($sformatf("u%0d.drain_timeout", i), 1, 0);
                break;
            end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic clear_log(input int i);
        log_sym[i].delete();
        log_cyc[i].delete();
    endtask

    // e packs entries {last, c1, c0}, entry k at bits [3k+2:3k].
    task automatic check_log(input int i, input string name, input logic [23:0] e, input int n, input bit consec);
        chk({name, ".count"}, log_sym[i].size(), n);
        for (int k = 0; k < n && k < log_sym[i].size(); k++) begin
            chk($sformatf("%s.sym%0d", name, k), int'(log_sym[i][k]), int'(e[3*k +: 3]));
            if (consec && k > 0)
                chk($sformatf("%s.gap%0d", name, k), log_cyc[i][k] - log_cyc[i][k-1], 1);
        end
    endtask

    task automatic rand_frames(input int i);
        for (int f = 0; f < 40; f++) begin
            send_frame(i, 16'($urandom), int'($urandom_range(1, 10)), 2);
            if ($urandom_range(0, 1) == 1) wait_idle(i);
        end
        wait_idle(i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tl  = '{2, 4};
        for (int i = 0; i < 2; i++) begin
            in_valid[i]   = 1'b0;
            in_bit[i]     = 1'b0;
            in_last[i]    = 1'b0;
            out_ready[i]  = 1'b1;
            ready_mode[i] = 0;
            pat_cnt[i]    = 0;
            hist[i]       = '0;
            in_frame[i]   = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.rst_out_valid", i), int'(out_valid[i]), 0);
            chk($sformatf("u%0d.rst_out_sym", i), int'(out_sym[i]), 0);
            chk($sformatf("u%0d.rst_out_last", i), int'(out_last[i]), 0);
            chk($sformatf("u%0d.rst_busy", i), int'(busy[i]), 0);
            chk($sformatf("u%0d.rst_in_ready", i), int'(in_ready[i]), 0);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);

        // 1,0,1,1 -> 11,10,00,01,01,11
        clear_log(0);
        send_frame(0, 16'b1101, 4, 0);
        wait_idle(0);
        check_log(0, "f1011", {6'b0, 3'b111, 3'b001, 3'b001, 3'b000, 3'b010, 3'b011}, 6, 1'b1);

        // single bit 1 -> 11,10,11
        clear_log(0);
        send_frame(0, 16'b1, 1, 0);
        wait_idle(0);
        check_log(0, "f1", {15'b0, 3'b111, 3'b010, 3'b011}, 3, 1'b1);

        // same 4-bit frame with out_ready pattern 1,0,0
        ready_mode[0] = 2;
        clear_log(0);
        send_frame(0, 16'b1101, 4, 0);
        wait_idle(0);
        check_log(0, "f1011_stall", {6'b0, 3'b111, 3'b001, 3'b001, 3'b000, 3'b010, 3'b011}, 6, 1'b0);
        ready_mode[0] = 0;
        repeat (2) @(posedge clk);

        // back-to-back frames: 0 then 1,1 -> 00,00,00,11,01,01,11
        clear_log(0);
        send_frame(0, 16'b0, 1, 0);
        send_frame(0, 16'b11, 2, 0);
        wait_idle(0);
        check_log(0, "b2b", {3'b0, 3'b111, 3'b001, 3'b001, 3'b011, 3'b100, 3'b000, 3'b000}, 7, 1'b1);

        // TAIL_LEN=4, frame 1 -> 11,10,11,00,00
        clear_log(1);
        send_frame(1, 16'b1, 1, 0);
        wait_idle(1);
        check_log(1, "tail4", {9'b0, 3'b100, 3'b000, 3'b011, 3'b010, 3'b011}, 5, 1'b1);

        // reset while in TAIL with a symbol held
        send_frame(0, 16'b1101, 4, 0);
        #2;
        in_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst.out_valid", int'(out_valid[0]), 0);
        chk("mid_rst.out_last", int'(out_last[0]), 0);
        chk("mid_rst.busy", int'(busy[0]), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        clear_log(0);
        send_frame(0, 16'b1101, 4, 0);
        wait_idle(0);
        check_log(0, "after_rst", {6'b0, 3'b111, 3'b001, 3'b001, 3'b000, 3'b010, 3'b011}, 6, 1'b1);

        // random frames with random backpressure on both instances
        ready_mode[0] = 1;
        ready_mode[1] = 1;
        fork
            rand_frames(0);
            rand_frames(1);
        join
        ready_mode[0] = 0;
        ready_mode[1] = 0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
